// File: rtl/ahb_cmd_manager_pkg.sv
// Shared AHB constants and manager state encoding used by the command manager and its bench.
package ahb_cmd_manager_pkg;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    MGR_IDLE,
    MGR_ADDR,
    MGR_DATA,
    MGR_ERR,
    MGR_RESP
  } MgrState;

endpackage

// File: rtl/ahb_cmd_manager_if.sv
// Command/response handshake plus AHB manager-side signals for ahb_cmd_manager.
interface ahb_cmd_manager_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic                 cmdValid;
  logic                 cmdReady;
  logic                 cmdWrite;
  logic [AddrWidth-1:0] cmdAddr;
  logic [DataWidth-1:0] cmdWData;
  logic                 rspValid;
  logic                 rspReady;
  logic [DataWidth-1:0] rspData;
  logic                 rspError;
  logic                 rspTimeout;
  logic [AddrWidth-1:0] addr;
  logic                 write;
  logic [1:0]           trans;
  logic [DataWidth-1:0] wData;
  logic [DataWidth-1:0] rData;
  logic                 readyIn;
  logic                 resp;

  modport master (
    input  cmdValid, cmdWrite, cmdAddr, cmdWData, rspReady, rData, readyIn, resp,
    output cmdReady, rspValid, rspData, rspError, rspTimeout, addr, write, trans, wData
  );

  modport slave (
    output cmdValid, cmdWrite, cmdAddr, cmdWData, rspReady, rData, readyIn, resp,
    input  cmdReady, rspValid, rspData, rspError, rspTimeout, addr, write, trans, wData
  );
endinterface

// File: rtl/ahb_cmd_manager_wait_timer.sv
// Saturating data-phase wait counter; expired_o flags the last permitted wait cycle.
module ahb_cmd_manager_wait_timer #(
  parameter int unsigned MaxWait = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int unsigned CntWidth = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(MaxWait - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LastCnt);
endmodule

// File: rtl/ahb_cmd_manager.sv
// Single-outstanding AHB manager: one command becomes one NONSEQ single transfer and one response.
module ahb_cmd_manager
  import ahb_cmd_manager_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 16
) (
  input  logic              clk,
  input  logic              reset,
  ahb_cmd_manager_if.master bus
);
  MgrState              state_q;
  logic                 cmdReady_q, rspValid_q, rspError_q, rspTimeout_q;
  logic [DataWidth-1:0] rspData_q, wData_q, wLatch_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 write_q;
  logic [1:0]           trans_q;

  logic timerClear, timerEnable, timerExpired;

  // Wait cycles count only while the subordinate stalls without signalling ERROR,
  // or while waiting for the second ERROR cycle.
  assign timerClear  = (state_q == MGR_ADDR);
  assign timerEnable = ((state_q == MGR_DATA) && !bus.readyIn && (bus.resp == RESP_OKAY)) ||
                       ((state_q == MGR_ERR)  && !bus.readyIn);

  ahb_cmd_manager_wait_timer #(
    .MaxWait(MaxWait)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (timerClear),
    .enable_i (timerEnable),
    .expired_o(timerExpired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= MGR_IDLE;
      cmdReady_q   <= 1'b1;
      rspValid_q   <= 1'b0;
      rspData_q    <= '0;
      rspError_q   <= 1'b0;
      rspTimeout_q <= 1'b0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      trans_q      <= TRANS_IDLE;
      wData_q      <= '0;
      wLatch_q     <= '0;
    end else begin
      case (state_q)
        MGR_IDLE: begin
          trans_q <= TRANS_IDLE;
          if (bus.cmdValid && cmdReady_q) begin
            addr_q       <= bus.cmdAddr;
            write_q      <= bus.cmdWrite;
            wLatch_q     <= bus.cmdWData;
            trans_q      <= TRANS_NONSEQ;
            cmdReady_q   <= 1'b0;
            rspError_q   <= 1'b0;
            rspTimeout_q <= 1'b0;
            state_q      <= MGR_ADDR;
          end
        end
        MGR_ADDR: begin
          if (bus.readyIn) begin
            trans_q <= TRANS_IDLE;
            if (write_q) wData_q <= wLatch_q;
            state_q <= MGR_DATA;
          end
        end
        MGR_DATA: begin
          if (bus.readyIn && (bus.resp == RESP_OKAY)) begin
            rspData_q  <= write_q ? '0 : bus.rData;
            rspError_q <= 1'b0;
            rspValid_q <= 1'b1;
            state_q    <= MGR_RESP;
          end else if (!bus.readyIn && (bus.resp == RESP_ERROR)) begin
            state_q <= MGR_ERR;
          end else if (bus.readyIn) begin
            rspError_q <= 1'b1;
            rspData_q  <= '0;
            rspValid_q <= 1'b1;
            state_q    <= MGR_RESP;
          end else if (timerExpired) begin
            rspTimeout_q <= 1'b1;
            rspData_q    <= '0;
            rspValid_q   <= 1'b1;
            state_q      <= MGR_RESP;
          end
        end
        MGR_ERR: begin
          if (bus.readyIn) begin
            rspError_q <= 1'b1;
            rspData_q  <= '0;
            rspValid_q <= 1'b1;
            state_q    <= MGR_RESP;
          end else if (timerExpired) begin
            rspTimeout_q <= 1'b1;
            rspData_q    <= '0;
            rspValid_q   <= 1'b1;
            state_q      <= MGR_RESP;
          end
        end
        MGR_RESP: begin
          if (bus.rspReady) begin
            rspValid_q <= 1'b0;
            cmdReady_q <= 1'b1;
            state_q    <= MGR_IDLE;
          end
        end
        default: state_q <= MGR_IDLE;
      endcase
    end
  end

  assign bus.cmdReady   = cmdReady_q;
  assign bus.rspValid   = rspValid_q;
  assign bus.rspData    = rspData_q;
  assign bus.rspError   = rspError_q;
  assign bus.rspTimeout = rspTimeout_q;
  assign bus.addr       = addr_q;
  assign bus.write      = write_q;
  assign bus.trans      = trans_q;
  assign bus.wData      = wData_q;
endmodule

// File: tb/tb_ahb_cmd_manager.sv
// Bench for ahb_cmd_manager: reactive memory subordinate plus transaction-level expectations.
module tb_ahb_cmd_manager;
  import ahb_cmd_manager_pkg::*;

  localparam int MaxWait = 16;

  logic clk;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  ahb_cmd_manager_if #(.AddrWidth(32), .DataWidth(32)) bus ();

  ahb_cmd_manager #(
    .AddrWidth(32),
    .DataWidth(32),
    .MaxWait  (MaxWait)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Subordinate: mode 0 = OKAY after sl_waits stalls, 1 = ERROR after sl_waits stalls, 2 = stall forever
  int          sl_mode  = 0;
  int          sl_waits = 0;
  bit          sl_clear = 1'b0;
  int          dph      = -1;
  bit          pend     = 1'b0;
  logic        sl_wr    = 1'b0;
  logic [1:0]  sl_idx   = '0;
  logic [31:0] smem [4];

  always @(negedge clk) begin
    logic rdy, rsp;
    logic [31:0] rd;
    if (sl_clear) begin
      dph = -1; pend = 1'b0; sl_clear = 1'b0;
    end
    if (pend) begin
      dph = 0; pend = 1'b0;
    end else if (dph >= 0) begin
      if (bus.readyIn) dph = -1;
      else dph++;
    end
    rdy = 1'b1; rsp = RESP_OKAY; rd = '0;
    if (dph >= 0) begin
      case (sl_mode)
        0: rdy = (dph >= sl_waits);
        1: begin
          if (dph < sl_waits) rdy = 1'b0;
          else if (dph == sl_waits) begin rdy = 1'b0; rsp = RESP_ERROR; end
          else rsp = RESP_ERROR;
        end
        default: rdy = 1'b0;
      endcase
      if (rdy && rsp == RESP_OKAY) begin
        if (sl_wr) smem[sl_idx] = bus.wData;
        else rd = smem[sl_idx];
      end
    end
    bus.readyIn = rdy;
    bus.resp    = rsp;
    bus.rData   = rd;
    if (bus.trans == TRANS_NONSEQ && rdy) begin
      pend = 1'b1; sl_idx = bus.addr[3:2]; sl_wr = bus.write;
    end
  end

  logic [31:0] model_mem [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input int mode, input int nw, input int hold);
    int exp_lat, lat, cnt;
    logic exp_err, exp_to;
    logic [31:0] exp_data, h_data;
    logic h_err, h_to;
    exp_err = 1'b0; exp_to = 1'b0; exp_data = '0;
    if (mode == 2 || (mode != 2 && nw >= MaxWait)) begin
      exp_to = 1'b1; exp_lat = 1 + MaxWait;
    end else if (mode == 1) begin
      exp_err = 1'b1; exp_lat = 3 + nw;
    end else begin
      exp_lat = 2 + nw;
      if (!wr) exp_data = model_mem[a[3:2]];
    end
    if (mode == 0 && !exp_to && wr) model_mem[a[3:2]] = d;

    sl_mode = mode; sl_waits = nw; sl_clear = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (!bus.cmdReady && cnt < 50) begin @(negedge clk); cnt++; end
    check("cmd_ready_idle", bus.cmdReady, 1'b1);
    bus.cmdValid = 1'b1; bus.cmdWrite = wr; bus.cmdAddr = a; bus.cmdWData = d;
    @(negedge clk);
    // Keep offering a different command; it must be ignored until the response is consumed.
    bus.cmdWrite = ~wr; bus.cmdAddr = $urandom; bus.cmdWData = $urandom;
    check("nonseq_trans", bus.trans, TRANS_NONSEQ);
    check("nonseq_addr", bus.addr, a);
    check("nonseq_write", bus.write, wr);
    check("busy_cmd_ready", bus.cmdReady, 1'b0);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk); lat++;
      if (bus.rspValid) break;
      check("dphase_trans", bus.trans, TRANS_IDLE);
      if (lat == 1 && wr) check("dphase_wdata", bus.wData, d);
    end
    check("latency", lat, exp_lat);
    check("rsp_valid", bus.rspValid, 1'b1);
    check("rsp_data", bus.rspData, exp_data);
    check("rsp_error", bus.rspError, exp_err);
    check("rsp_timeout", bus.rspTimeout, exp_to);
    h_data = bus.rspData; h_err = bus.rspError; h_to = bus.rspTimeout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rspValid, 1'b1);
      check("hold_data", bus.rspData, h_data);
      check("hold_flags", {bus.rspError, bus.rspTimeout}, {h_err, h_to});
      check("hold_cmd_ready", bus.cmdReady, 1'b0);
      check("hold_trans", bus.trans, TRANS_IDLE);
    end
    bus.rspReady = 1'b1;
    @(negedge clk);
    bus.rspReady = 1'b0; bus.cmdValid = 1'b0;
    check("done_valid", bus.rspValid, 1'b0);
    check("done_cmd_ready", bus.cmdReady, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.cmdValid = 1'b0; bus.cmdWrite = 1'b0; bus.cmdAddr = '0; bus.cmdWData = '0;
    bus.rspReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smem[i] = $urandom; model_mem[i] = smem[i];
    end
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmdReady, 1'b1);
    check("rst_rsp_valid", bus.rspValid, 1'b0);
    check("rst_rsp_data", bus.rspData, 32'h0);
    check("rst_flags", {bus.rspError, bus.rspTimeout}, 2'b00);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_write", bus.write, 1'b0);
    check("rst_trans", bus.trans, TRANS_IDLE);
    check("rst_wdata", bus.wData, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 32'h4, 32'hDEADBEEF, 0, 0, 0);
    do_txn(1'b0, 32'h4, 32'h0, 0, 0, 0);
    check("readback_model", model_mem[1], 32'hDEADBEEF);
    do_txn(1'b0, 32'h4, 32'h0, 0, 3, 5);
    do_txn(1'b0, 32'h8, 32'h0, 1, 0, 1);
    do_txn(1'b0, 32'hC, 32'h0, 2, 0, 2);
    do_txn(1'b1, 32'h8, 32'h12345678, 0, 0, 0);
    do_txn(1'b0, 32'h8, 32'h0, 0, 15, 0);
    do_txn(1'b1, 32'h0, 32'hCAFEF00D, 1, 2, 0);

    for (int t = 0; t < 24; t++) begin
      int sel, mode, nw;
      logic [31:0] a;
      sel  = $urandom_range(0, 9);
      mode = (sel < 6) ? 0 : ((sel < 9) ? 1 : 2);
      nw   = (mode == 0) ? $urandom_range(0, 4) : $urandom_range(0, 2);
      a    = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      do_txn(1'($urandom_range(0, 1)), a, $urandom, mode, nw, $urandom_range(0, 3));
    end

    // Asynchronous reset while the subordinate is stalling the data phase.
    sl_mode = 2; sl_waits = 0; sl_clear = 1'b1;
    @(negedge clk);
    bus.cmdValid = 1'b1; bus.cmdWrite = 1'b0; bus.cmdAddr = 32'h4;
    @(negedge clk);
    bus.cmdValid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_trans", bus.trans, TRANS_IDLE);
    check("pre_rst_busy", bus.cmdReady, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_trans", bus.trans, TRANS_IDLE);
    check("async_rst_cmd_ready", bus.cmdReady, 1'b1);
    check("async_rst_rsp_valid", bus.rspValid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", bus.rspValid, 1'b0);
    end
    do_txn(1'b0, 32'h4, 32'h0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
